// File: rtl/cell_rect_sequencer_if.sv
// Cell paint request channel plus line command channel toward the line drawer.
// master = requester / line consumer side, slave = the sequencer.
`timescale 1ns/1ps
interface cell_rect_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_row;
    logic [3:0]  req_col;
    logic [2:0]  req_color;
    logic        req_mode;
    logic        line_valid;
    logic        line_ready;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] y;
    logic [2:0]  color_line;
    logic        done;
    logic        err;

    modport master (
        output req_valid, req_row, req_col, req_color, req_mode, line_ready,
        input  req_ready, line_valid, x0, x1, y, color_line, done, err
    );

    modport slave (
        input  req_valid, req_row, req_col, req_color, req_mode, line_ready,
        output req_ready, line_valid, x0, x1, y, color_line, done, err
    );
endinterface

// File: rtl/cell_rect_sequencer.sv
// Turns one cell paint request into horizontal line commands (fill or outline); first line 1 cycle after accept.
// Commands held stable under line_ready backpressure; requests accepted only in IDLE.
`timescale 1ns/1ps
module cell_rect_sequencer #(
    parameter int CELL_SIZE = 40,
    parameter int GRID_X0   = 100,
    parameter int GRID_Y0   = 20,
    parameter int INSET     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cell_rect_sequencer_if.slave  bus
);
    localparam logic [10:0] LW_CELL  = 11'(CELL_SIZE);
    localparam logic [10:0] LW_X0    = 11'(GRID_X0);
    localparam logic [10:0] LW_Y0    = 11'(GRID_Y0);
    localparam logic [10:0] LW_INSET = 11'(INSET);
    localparam logic [10:0] LW_SPAN  = 11'(CELL_SIZE - 2*INSET - 1);

    typedef enum logic [1:0] {IDLE, CHECK, EMIT, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_row;
    logic [3:0]  r_col;
    logic [2:0]  r_color;
    logic        r_mode;
    logic        r_side;
    logic [10:0] r_l;
    logic [10:0] r_r;
    logic [10:0] r_t;
    logic [10:0] r_b;
    logic [10:0] r_x0;
    logic [10:0] r_x1;
    logic [10:0] r_y;
    logic [2:0]  r_color_line;
    logic        r_req_ready;
    logic        r_line_valid;
    logic        r_done;
    logic        r_err;

    logic [10:0] w_l;
    logic [10:0] w_t;
    logic [10:0] w_y_nxt;
    logic        w_range_bad;
    logic        w_hs;

    assign w_l         = LW_X0 + 11'(r_col) * LW_CELL + LW_INSET;
    assign w_t         = LW_Y0 + 11'(r_row) * LW_CELL + LW_INSET;
    assign w_y_nxt     = r_y + 11'd1;
    assign w_range_bad = (r_row > 4'd8) || (r_col > 4'd8);
    assign w_hs        = r_line_valid && bus.line_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_color      <= '0;
            r_mode       <= 1'b0;
            r_side       <= 1'b0;
            r_l          <= '0;
            r_r          <= '0;
            r_t          <= '0;
            r_b          <= '0;
            r_x0         <= '0;
            r_x1         <= '0;
            r_y          <= '0;
            r_color_line <= '0;
            r_req_ready  <= 1'b1;
            r_line_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_row       <= bus.req_row;
                        r_col       <= bus.req_col;
                        r_color     <= bus.req_color;
                        r_mode      <= bus.req_mode;
                        r_req_ready <= 1'b0;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_range_bad) begin
                        r_err       <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_l          <= w_l;
                        r_r          <= w_l + LW_SPAN;
                        r_t          <= w_t;
                        r_b          <= w_t + LW_SPAN;
                        r_x0         <= w_l;
                        r_x1         <= w_l + LW_SPAN;
                        r_y          <= w_t;
                        r_color_line <= r_color;
                        r_side       <= 1'b0;
                        r_line_valid <= 1'b1;
                        r_state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_hs) begin
                        if (r_y == r_b) begin
                            r_line_valid <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= DONE;
                        end else if (!r_mode) begin
                            r_y <= w_y_nxt;
                        end else if ((r_y != r_t) && !r_side) begin
                            // middle row: left pixel done, now the right pixel
                            r_x0   <= r_r;
                            r_x1   <= r_r;
                            r_side <= 1'b1;
                        end else begin
                            r_side <= 1'b0;
                            r_y    <= w_y_nxt;
                            r_x0   <= r_l;
                            r_x1   <= (w_y_nxt == r_b) ? r_r : r_l;
                        end
                    end
                end
                DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_req_ready  <= 1'b1;
                    r_line_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.line_valid = r_line_valid;
    assign bus.x0         = r_x0;
    assign bus.x1         = r_x1;
    assign bus.y          = r_y;
    assign bus.color_line = r_color_line;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule
